key_loader: RTL and testbench

Serial key-programming stage that sits directly upstream of the locked controller FSM and drives its key inputs (keyinput0..). It accepts a key bit-serially over a valid/ready handshake and checks an even-parity trailer. On a good load it latches the key and holds it stable until reset. Until a key is successfully locked, its key output is forced to all-zero.

---
 rtl/key_loader_pkg.sv | 14 +
 rtl/key_loader_if.sv | 39 +++
 rtl/key_shift_reg.sv | 36 +++
 rtl/key_loader.sv | 128 ++++++++++++
 tb/tb_key_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/key_loader_pkg.sv
// Shared types and defaults for the serial key loader and its integration top.
package key_loader_pkg;

    localparam int unsigned KEY_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        CHECK  = 3'd2,
        LOCKED = 3'd3,
        ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/key_loader_if.sv
// Key-programming bus: serial valid/ready key stream in, latched key and status out.
interface key_loader_if
    import key_loader_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = KEY_WIDTH_DEFAULT
);

    logic                 load_start;
    logic                 key_bit;
    logic                 key_valid;
    logic                 key_ready;
    logic [KEY_WIDTH-1:0] keyinput;
    logic                 key_locked;
    logic                 key_err;
    logic                 busy;

    modport master (
        output load_start,
        output key_bit,
        output key_valid,
        input  key_ready,
        input  keyinput,
        input  key_locked,
        input  key_err,
        input  busy
    );

    modport slave (
        input  load_start,
        input  key_bit,
        input  key_valid,
        output key_ready,
        output keyinput,
        output key_locked,
        output key_err,
        output busy
    );

endinterface

// File: rtl/key_shift_reg.sv
// MSB-first serial-in shift register with a running XOR of every bit shifted in.
module key_shift_reg
    import key_loader_pkg::*;
#(
    parameter int unsigned WIDTH = KEY_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_val,
    output logic [WIDTH-1:0] value,
    output logic             parity
);

    logic [WIDTH-1:0] shift_next;

    generate
        if (WIDTH == 1) begin : g_single
            assign shift_next = bit_val;
        end else begin : g_multi
            assign shift_next = {value[WIDTH-2:0], bit_val};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value  <= '0;
            parity <= 1'b0;
        end else if (shift_en) begin
            value  <= shift_next;
            parity <= parity ^ bit_val;
        end
    end

endmodule

// File: rtl/key_loader.sv
// One-time key loader: collects a serial key plus even-parity trailer and, on a good
// load, latches the key for the locked FSM; keyinput stays zero until then.
module key_loader
    import key_loader_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = KEY_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    key_loader_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(KEY_WIDTH + 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 clear;
    logic                 shift_en;
    logic                 accept;
    logic [KEY_WIDTH-1:0] shift_value;
    logic                 parity;
    logic [KEY_WIDTH-1:0] keyinput_next;
    logic                 locked_next;
    logic                 err_next;
    logic                 ready_next;
    logic                 busy_next;

    assign accept = bus.key_valid && bus.key_ready;

    key_shift_reg #(
        .WIDTH (KEY_WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .shift_en (shift_en),
        .bit_val  (bus.key_bit),
        .value    (shift_value),
        .parity   (parity)
    );

    // State, counter and every externally visible output are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            bus.keyinput   <= '0;
            bus.key_locked <= 1'b0;
            bus.key_err    <= 1'b0;
            bus.key_ready  <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            bus.keyinput   <= keyinput_next;
            bus.key_locked <= locked_next;
            bus.key_err    <= err_next;
            bus.key_ready  <= ready_next;
            bus.busy       <= busy_next;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_next    = state;
        count_next    = count;
        clear         = 1'b0;
        shift_en      = 1'b0;
        keyinput_next = bus.keyinput;
        locked_next   = bus.key_locked;
        err_next      = bus.key_err;

        case (state)
            IDLE, ERROR: begin
                if (bus.load_start) begin
                    state_next = SHIFT;
                    clear      = 1'b1;
                    count_next = '0;
                    err_next   = 1'b0;
                end
            end

            SHIFT: begin
                if (accept) begin
                    shift_en   = 1'b1;
                    count_next = count + CNT_W'(1);
                    if (count == CNT_W'(KEY_WIDTH - 1)) begin
                        state_next = CHECK;
                    end
                end
            end

            CHECK: begin
                if (accept) begin
                    if ((parity ^ bus.key_bit) == 1'b0) begin
                        state_next    = LOCKED;
                        keyinput_next = shift_value;
                        locked_next   = 1'b1;
                    end else begin
                        state_next    = ERROR;
                        keyinput_next = '0;
                        err_next      = 1'b1;
                    end
                end
            end

            LOCKED: begin
                // Key is one-time-programmable until the next reset.
                state_next = LOCKED;
            end

            default: begin
                state_next    = IDLE;
                count_next    = '0;
                clear         = 1'b1;
                keyinput_next = '0;
                locked_next   = 1'b0;
                err_next      = 1'b0;
            end
        endcase

        ready_next = (state_next == SHIFT) || (state_next == CHECK);
        busy_next  = (state_next == SHIFT) || (state_next == CHECK);
    end

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: table of key loads with a result scoreboard,
// plus hand-written abort, idle-noise and post-lock sequences.
module tb_key_loader;
    import key_loader_pkg::*;

    localparam int unsigned KW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    key_loader_if #(.KEY_WIDTH(KW)) ifc ();

    key_loader #(.KEY_WIDTH(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        logic          locked;
        logic          err;
        logic [KW-1:0] key;
    } exp_t;

    typedef struct {
        logic          rst_first;
        logic [KW-1:0] key;
        logic          par;
        int            stalls;
        logic          exp_lock;
        logic          exp_err;
        logic [KW-1:0] exp_key;
        logic          valid_at_start;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        ifc.load_start = 1'b0;
        ifc.key_valid  = 1'b0;
        ifc.key_bit    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one full load (start, KW key bits MSB first, parity) and scores the result.
    task automatic send_key(input logic [KW-1:0] key, input logic par, input int stalls,
                            input logic exp_lock, input logic exp_err, input logic [KW-1:0] exp_key,
                            input logic valid_at_start, output int cycles);
        exp_t      e;
        logic [KW:0] beats;
        int        idx;
        int        left;
        int        budget;
        logic      rdy;

        beats    = {key, par};
        e.locked = exp_lock;
        e.err    = exp_err;
        e.key    = exp_key;
        sb.push_back(e);

        ifc.load_start = 1'b1;
        ifc.key_valid  = valid_at_start;
        ifc.key_bit    = 1'b1;
        @(posedge clk);
        #1;
        ifc.load_start = 1'b0;
        ifc.key_valid  = 1'b0;
        cycles         = 1;
        check("busy_after_start", 32'(ifc.busy), 32'(1));
        check("err_clear_after_start", 32'(ifc.key_err), 32'(0));

        left   = stalls;
        idx    = 0;
        budget = 0;
        while (idx < int'(KW) + 1 && budget < 60) begin
            if (left > 0 && idx > 0 && idx < int'(KW) &&
                ($urandom_range(0, 2) == 0 || left >= int'(KW) - idx)) begin
                ifc.key_valid = 1'b0;
                left--;
            end else begin
                ifc.key_valid = 1'b1;
                ifc.key_bit   = beats[KW-idx];
            end
            rdy = ifc.key_ready;
            @(posedge clk);
            #1;
            cycles++;
            budget++;
            if (ifc.key_valid && rdy) idx++;
        end
        ifc.key_valid = 1'b0;

        if (idx < int'(KW) + 1) begin
            checks++;
            failures++;
            $display("FAIL load_timeout accepted=%0d required=%0d", idx, KW + 1);
        end

        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb.pop_front();
            check("key_locked", 32'(ifc.key_locked), 32'(e.locked));
            check("key_err", 32'(ifc.key_err), 32'(e.err));
            check("keyinput", 32'(ifc.keyinput), 32'(e.key));
            check("busy_done", 32'(ifc.busy), 32'(0));
        end
    endtask

    initial begin
        int cyc;

        rst            = 1'b1;
        ifc.load_start = 1'b0;
        ifc.key_valid  = 1'b0;
        ifc.key_bit    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_key_ready", 32'(ifc.key_ready), 32'(0));
        check("rst_busy", 32'(ifc.busy), 32'(0));
        check("rst_keyinput", 32'(ifc.keyinput), 32'(0));
        check("rst_key_locked", 32'(ifc.key_locked), 32'(0));
        check("rst_key_err", 32'(ifc.key_err), 32'(0));

        // Valid noise in IDLE without load_start must be ignored.
        ifc.key_valid = 1'b1;
        ifc.key_bit   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("idle_ready", 32'(ifc.key_ready), 32'(0));
            check("idle_busy", 32'(ifc.busy), 32'(0));
            check("idle_keyinput", 32'(ifc.keyinput), 32'(0));
        end
        ifc.key_valid = 1'b0;
        send_key(8'h5A, 1'b0, 0, 1'b1, 1'b0, 8'h5A, 1'b0, cyc);
        check("idle_then_load_cycles", 32'(cyc), 32'(10));

        vecs[0] = '{1'b1, 8'hA5, 1'b0, 0, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{1'b1, 8'hA5, 1'b1, 0, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 8'h3C, 1'b0, 0, 1'b1, 1'b0, 8'h3C, 1'b0};
        vecs[3] = '{1'b1, 8'hFF, 1'b0, 3, 1'b1, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{1'b1, 8'h00, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 8'h7F, 1'b1, 0, 1'b1, 1'b0, 8'h7F, 1'b0};
        vecs[6] = '{1'b1, 8'h01, 1'b0, 2, 1'b0, 1'b1, 8'h00, 1'b0};

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].rst_first) do_reset();
            send_key(vecs[v].key, vecs[v].par, vecs[v].stalls, vecs[v].exp_lock,
                     vecs[v].exp_err, vecs[v].exp_key, vecs[v].valid_at_start, cyc);
            check($sformatf("vec%0d_cycles", v), 32'(cyc), 32'(10 + vecs[v].stalls));
        end

        // Reset mid-load discards the partial key.
        do_reset();
        ifc.load_start = 1'b1;
        @(posedge clk);
        #1;
        ifc.load_start = 1'b0;
        ifc.key_valid  = 1'b1;
        ifc.key_bit    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_busy_before_rst", 32'(ifc.busy), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        ifc.key_valid = 1'b0;
        check("abort_ready", 32'(ifc.key_ready), 32'(0));
        check("abort_busy", 32'(ifc.busy), 32'(0));
        check("abort_keyinput", 32'(ifc.keyinput), 32'(0));
        check("abort_locked", 32'(ifc.key_locked), 32'(0));
        send_key(8'h81, 1'b0, 0, 1'b1, 1'b0, 8'h81, 1'b0, cyc);

        // Once locked, further load attempts are ignored.
        do_reset();
        send_key(8'hA5, 1'b0, 0, 1'b1, 1'b0, 8'hA5, 1'b0, cyc);
        ifc.load_start = 1'b1;
        @(posedge clk);
        #1;
        ifc.load_start = 1'b0;
        ifc.key_valid  = 1'b1;
        ifc.key_bit    = 1'b0;
        for (int i = 0; i < KW + 1; i++) begin
            @(posedge clk);
            #1;
            check("relock_ready", 32'(ifc.key_ready), 32'(0));
            check("relock_keyinput", 32'(ifc.keyinput), 32'(8'hA5));
            check("relock_locked", 32'(ifc.key_locked), 32'(1));
        end
        ifc.key_valid = 1'b0;
        check("relock_busy", 32'(ifc.busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
